apb_timer_mc: RTL and testbench
===============================

# apb_timer_mc

Multi-channel APB timer peripheral for the RISC-V APB subsystem, sitting on the APB bus as a slave alongside the other peripherals. It provides NUM_CH independent prescaled counters. Each counter can run up or down, in periodic or one-shot mode, and has a sticky update flag. A combined interrupt line goes to the core.

## Interface
- NUM_CH, 4: number of timer channels, 1..8.
- CNT_W, 32: width of PSC, ARR and counter, 8..32. Writes ignore PWDATA[31:CNT_W]; reads zero-extend.

Ports:
- PCLK  in  1  single clock for bus and all channels.
- PRESET  in  1  reset, synchronous, active-low. Sampled on the rising edge of PCLK.
- PADDR  in  8  byte address. [7:5] selects the channel; [4:2] selects the register; [1:0] is ignored.
- PWDATA  in  32  write data.
- PWRITE  in  1  1 = write, 0 = read.
- PENABLE  in  1  APB access phase.
- PSEL  in  1  slave select.
- PRDATA  out  32  read data, registered.
- PREADY  out  1  transfer complete, registered.
- PSLVERR  out  1  error response, valid while PREADY = 1.
- IRQ  out  1  OR over all channels of (UIF & IE).

## Operation
- Register map, per channel, offset from channel base (ch × 0x20):
  - 0x00 CTRL: [0] EN, [1] CLR, [2] OPM (1 = one-shot), [3] DIR (0 = up, 1 = down), [4] IE.
  - 0x04 PSC.
  - 0x08 ARR.
  - 0x0C CNT, read-only; writes are accepted and ignored.
  - 0x10 SR: [0] UIF, write-1-to-clear.
  - 0x14–0x1C reserved.
- Errors: a channel index ≥ NUM_CH or a reserved offset gives PSLVERR = 1 and PRDATA = 0, with no register change.
- CLR is a strobe. Writing 1 zeroes the prescaler and CNT, or loads CNT = ARR when DIR = 1. UIF is not affected. CLR always reads 0.
- Prescaler: while EN = 1, psc_cnt increments every clock. When psc_cnt == PSC, psc_cnt goes to 0 and the channel generates a tick. The counter therefore advances once every PSC+1 clocks. While EN = 0, psc_cnt and CNT hold their values.
- Up mode, on a tick:
  - if CNT ≥ ARR: CNT goes to 0 and an update event occurs;
  - otherwise CNT = CNT+1.
- Down mode, on a tick:
  - if CNT == 0 or CNT > ARR: CNT = ARR and an update event occurs;
  - otherwise CNT = CNT−1.
- Update event: UIF is set to 1. If OPM = 1, EN is also cleared by hardware in the same edge, and CNT takes its reload value (0 for up, ARR for down).
- ARR = 0 produces an update on every tick. PSC = 0 gives a tick every clock.
- Writes to PSC or ARR take effect immediately. There is no shadow register; the new value is used in the next comparison.
- Channels share nothing except the bus and IRQ.

## Timing
- Reset (PRESET = 0 at an edge) sets all registers, psc_cnt, CNT, PRDATA, PREADY, PSLVERR and IRQ to 0, including a reset that arrives mid-transfer or mid-count.
- APB handshake: exactly one wait state.
  - An access is accepted when PSEL & PENABLE & !PREADY.
  - At that edge, a write updates the register and a read loads PRDATA.
  - PREADY = 1 (and PSLVERR, if applicable) for exactly the next cycle, then returns to 0 even if PSEL stays high.
  - There is no double write.
- A CTRL write with EN = 1 starts counting in the following cycle. The first tick comes PSC+1 clocks after that.
- UIF and the one-shot EN clear are visible in the cycle after the update edge. IRQ asserts in that same cycle, being combinational from the registers.
- Simultaneous events:
  - CLR write vs. tick in the same cycle: CLR wins.
  - SR W1C vs. an update in the same cycle: UIF stays 1 (set wins).
  - CTRL write vs. one-shot EN clear: the bus write wins.
- A read of CNT returns its value before the accept edge.

## Test plan
- Reset: hold PRESET = 0 for 2 cycles mid-count with EN = 1, then release. All reads return 0, IRQ = 0, and CNT does not move.
- Periodic up count: ch0, PSC = 3, ARR = 4, CTRL = 0x11. CNT steps 0,1,2,3,4,0 every 4 clocks. UIF rises after 20 clocks and IRQ = 1. Writing SR = 1 clears IRQ on the next cycle.
- One-shot down count: ch2, PSC = 0, ARR = 3, CNT loaded by CLR, CTRL = 0x0D. CNT follows 3,2,1,0, then reloads to 3 once. EN reads 0 and CNT then stays at 3.
- Bus protocol: back-to-back writes with PSEL held high. Each write produces a single one-cycle PREADY pulse. Writing 0xFFFF_FFFF to ARR with CNT_W = 16 reads back 0x0000_FFFF. A read of offset 0x14 or of channel 5 with NUM_CH = 4 gives PSLVERR = 1 and PRDATA = 0.
- Collisions: issue SR W1C on the exact update edge, and UIF stays 1. Issue a CLR write on a tick edge, and CNT = 0 with psc_cnt = 0.
- Boundaries: lower ARR from 10 to 2 while CNT = 7 in up mode, and the next tick wraps CNT to 0 with UIF set. With PSC = 0 and ARR = 0, UIF sets on every clock.

Source files
------------

// File: rtl/apb_timer_mc_if.sv
// APB bus bundle between the subsystem master and the apb_timer_mc slave.
interface apb_timer_mc_if;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer: NUM_CH prescaled up/down counters, periodic or one-shot,
// sticky update flags and a combined interrupt. One APB wait state per access.
module apb_timer_mc #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic          PCLK,
    input  logic          PRESET,
    apb_timer_mc_if.slave apb,
    output logic          IRQ
);
    localparam logic [2:0]       OFF_CTRL = 3'd0;
    localparam logic [2:0]       OFF_PSC  = 3'd1;
    localparam logic [2:0]       OFF_ARR  = 3'd2;
    localparam logic [2:0]       OFF_CNT  = 3'd3;
    localparam logic [2:0]       OFF_SR   = 3'd4;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [2:0]        ch_idx;
    logic [2:0]        reg_idx;
    logic              accept;
    logic              addr_err;
    logic              wr_en;
    logic [CNT_W-1:0]  wdata_c;
    logic [31:0]       rd_word [NUM_CH];
    logic [NUM_CH-1:0] irq_vec;
    logic [31:0]       rdata_d;
    logic [31:0]       prdata_q;
    logic              pready_q;
    logic              pslverr_q;
    logic              unused_addr_bits;

    assign ch_idx           = apb.PADDR[7:5];
    assign reg_idx          = apb.PADDR[4:2];
    assign unused_addr_bits = ^apb.PADDR[1:0];
    assign accept           = apb.PSEL && apb.PENABLE && !pready_q;
    assign addr_err         = (32'(ch_idx) >= NUM_CH) || (reg_idx > OFF_SR);
    assign wr_en            = accept && apb.PWRITE && !addr_err;
    assign wdata_c          = apb.PWDATA[CNT_W-1:0];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic             en_q, opm_q, dir_q, ie_q, uif_q;
        logic             en_d, opm_d, dir_d, ie_d, uif_d;
        logic [CNT_W-1:0] psc_q, arr_q, cnt_q, psc_cnt_q;
        logic [CNT_W-1:0] psc_d, arr_d, cnt_d, psc_cnt_d;
        logic             sel, clr, tick, wrap, upd;
        logic [31:0]      rd_loc;

        assign sel  = wr_en && (ch_idx == 3'(gi));
        assign clr  = sel && (reg_idx == OFF_CTRL) && apb.PWDATA[1];
        assign tick = en_q && (psc_cnt_q == psc_q);
        assign wrap = dir_q ? ((cnt_q == '0) || (cnt_q > arr_q)) : (cnt_q >= arr_q);
        // A CLR landing on a tick discards that tick entirely, update included.
        assign upd  = tick && wrap && !clr;

        always_comb begin
            en_d      = en_q;
            opm_d     = opm_q;
            dir_d     = dir_q;
            ie_d      = ie_q;
            uif_d     = uif_q;
            psc_d     = psc_q;
            arr_d     = arr_q;
            cnt_d     = cnt_q;
            psc_cnt_d = psc_cnt_q;
            if (en_q) begin
                psc_cnt_d = tick ? '0 : psc_cnt_q + ONE;
            end
            if (tick) begin
                if (wrap) begin
                    cnt_d = dir_q ? arr_q : '0;
                end else begin
                    cnt_d = dir_q ? cnt_q - ONE : cnt_q + ONE;
                end
            end
            if (upd) begin
                uif_d = 1'b1;
                if (opm_q) begin
                    en_d = 1'b0;
                end
            end
            // Bus writes are applied last so they override the hardware one-shot stop.
            if (sel) begin
                case (reg_idx)
                    OFF_CTRL: begin
                        en_d  = apb.PWDATA[0];
                        opm_d = apb.PWDATA[2];
                        dir_d = apb.PWDATA[3];
                        ie_d  = apb.PWDATA[4];
                        if (apb.PWDATA[1]) begin
                            psc_cnt_d = '0;
                            cnt_d     = apb.PWDATA[3] ? arr_q : '0;
                        end
                    end
                    OFF_PSC: psc_d = wdata_c;
                    OFF_ARR: arr_d = wdata_c;
                    OFF_SR: begin
                        if (apb.PWDATA[0] && !upd) begin
                            uif_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge PCLK) begin
            if (!PRESET) begin
                en_q      <= 1'b0;
                opm_q     <= 1'b0;
                dir_q     <= 1'b0;
                ie_q      <= 1'b0;
                uif_q     <= 1'b0;
                psc_q     <= '0;
                arr_q     <= '0;
                cnt_q     <= '0;
                psc_cnt_q <= '0;
            end else begin
                en_q      <= en_d;
                opm_q     <= opm_d;
                dir_q     <= dir_d;
                ie_q      <= ie_d;
                uif_q     <= uif_d;
                psc_q     <= psc_d;
                arr_q     <= arr_d;
                cnt_q     <= cnt_d;
                psc_cnt_q <= psc_cnt_d;
            end
        end

        always_comb begin
            rd_loc = '0;
            case (reg_idx)
                OFF_CTRL: rd_loc = {27'd0, ie_q, dir_q, opm_q, 1'b0, en_q};
                OFF_PSC:  rd_loc = 32'(psc_q);
                OFF_ARR:  rd_loc = 32'(arr_q);
                OFF_CNT:  rd_loc = 32'(cnt_q);
                OFF_SR:   rd_loc = {31'd0, uif_q};
                default:  rd_loc = '0;
            endcase
        end

        assign rd_word[gi] = rd_loc;
        assign irq_vec[gi] = uif_q && ie_q;
    end

    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!addr_err && (ch_idx == 3'(i))) begin
                rdata_d = rd_word[i];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= accept;
            pslverr_q <= accept && addr_err;
            if (accept) begin
                prdata_q <= apb.PWRITE ? 32'd0 : rdata_d;
            end
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign IRQ         = |irq_vec;
endmodule

// File: tb/tb_apb_timer_mc.sv
// Bench for apb_timer_mc: directed scenarios plus random APB traffic, all checked
// against a cycle-level behavioural model of the timer channels.
module tb_apb_timer_mc;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int unsigned MASK = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rstn;
    logic irq;
    apb_timer_mc_if bus();

    apb_timer_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .PCLK   (clk),
        .PRESET (rstn),
        .apb    (bus),
        .IRQ    (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_en [NUM_CH];
    bit          m_opm[NUM_CH];
    bit          m_dir[NUM_CH];
    bit          m_ie [NUM_CH];
    bit          m_uif[NUM_CH];
    int unsigned m_psc[NUM_CH];
    int unsigned m_arr[NUM_CH];
    int unsigned m_cnt[NUM_CH];
    int unsigned m_pcnt[NUM_CH];
    bit          m_ready;
    bit          m_err;
    logic [31:0] m_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_value(input int c, input int o);
        case (o)
            0: return 32'({m_ie[c], m_dir[c], m_opm[c], 1'b0, m_en[c]});
            1: return m_psc[c];
            2: return m_arr[c];
            3: return m_cnt[c];
            4: return 32'(m_uif[c]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit model_irq();
        bit r = 1'b0;
        for (int c = 0; c < NUM_CH; c++) r |= m_uif[c] & m_ie[c];
        return r;
    endfunction

    // Advance the model across one rising edge, then compare the DUT on the falling edge.
    task automatic cyc();
        bit          acc, bad, wr, upd, hit;
        int          ch, off;
        logic [31:0] wd;
        acc = bus.PSEL && bus.PENABLE && !m_ready;
        ch  = int'(bus.PADDR[7:5]);
        off = int'(bus.PADDR[4:2]);
        wd  = bus.PWDATA;
        wr  = bus.PWRITE;
        bad = (ch >= NUM_CH) || (off > 4);
        if (!rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_en[c] = 0; m_opm[c] = 0; m_dir[c] = 0; m_ie[c] = 0; m_uif[c] = 0;
                m_psc[c] = 0; m_arr[c] = 0; m_cnt[c] = 0; m_pcnt[c] = 0;
            end
            m_ready = 0; m_err = 0; m_rdata = 0;
        end else begin
            if (acc) m_rdata = (wr || bad) ? 32'd0 : reg_value(ch, off);
            m_ready = acc;
            m_err   = acc && bad;
            for (int c = 0; c < NUM_CH; c++) begin
                hit = acc && wr && !bad && (ch == c);
                upd = 0;
                if (!(hit && off == 0 && wd[1]) && m_en[c]) begin
                    if (m_pcnt[c] == m_psc[c]) begin
                        m_pcnt[c] = 0;
                        if (!m_dir[c]) begin
                            if (m_cnt[c] >= m_arr[c]) begin m_cnt[c] = 0; upd = 1; end
                            else m_cnt[c] = m_cnt[c] + 1;
                        end else begin
                            if (m_cnt[c] == 0 || m_cnt[c] > m_arr[c]) begin m_cnt[c] = m_arr[c]; upd = 1; end
                            else m_cnt[c] = m_cnt[c] - 1;
                        end
                    end else begin
                        m_pcnt[c] = (m_pcnt[c] + 1) & MASK;
                    end
                end
                if (upd) begin
                    m_uif[c] = 1;
                    if (m_opm[c]) m_en[c] = 0;
                end
                if (hit) begin
                    case (off)
                        0: begin
                            m_en[c] = wd[0]; m_opm[c] = wd[2]; m_dir[c] = wd[3]; m_ie[c] = wd[4];
                            if (wd[1]) begin
                                m_pcnt[c] = 0;
                                m_cnt[c]  = wd[3] ? m_arr[c] : 0;
                            end
                        end
                        1: m_psc[c] = wd & MASK;
                        2: m_arr[c] = wd & MASK;
                        4: if (wd[0] && !upd) m_uif[c] = 0;
                        default: ;
                    endcase
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("pready", 32'(bus.PREADY), 32'(m_ready));
        check("pslverr", 32'(bus.PSLVERR), 32'(m_err));
        check("irq", 32'(irq), 32'(model_irq()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic apb(input bit wr, input int ch, input int off, input logic [31:0] data,
                       input bit hold, output logic [31:0] rdata, output logic err);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = 8'((ch << 5) | (off << 2));
        bus.PWDATA  = data;
        cyc();
        bus.PENABLE = 1'b1;
        cyc();
        rdata = bus.PRDATA;
        err   = bus.PSLVERR;
        if (!wr) check("prdata", bus.PRDATA, m_rdata);
        $display("apb %s ch=%0d off=%02h wdata=%08h rdata=%08h err=%0b",
                 wr ? "WR" : "RD", ch, off * 4, data, bus.PRDATA, bus.PSLVERR);
        cyc();
        bus.PENABLE = 1'b0;
        if (!hold) bus.PSEL = 1'b0;
    endtask

    task automatic wr(input int ch, input int off, input logic [31:0] data);
        logic [31:0] d;
        logic e;
        apb(1'b1, ch, off, data, 1'b0, d, e);
    endtask

    task automatic rd(input int ch, input int off, output logic [31:0] data);
        logic e;
        apb(1'b0, ch, off, 32'd0, 1'b0, data, e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          waited;

        rstn = 1'b0;
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
        @(negedge clk);
        idle(3);
        rstn = 1'b1;
        idle(1);

        // Reset in the middle of a running count
        wr(0, 1, 1);
        wr(0, 0, 32'h11);
        idle(7);
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(3);
        rd(0, 3, d); check("rst_cnt", d, 0);
        rd(0, 0, d); check("rst_ctrl", d, 0);
        rd(0, 1, d); check("rst_psc", d, 0);
        idle(4);
        rd(0, 3, d); check("rst_cnt_hold", d, 0);
        check("rst_irq", 32'(irq), 0);

        // Periodic up count on ch0
        wr(0, 1, 3);
        wr(0, 2, 4);
        wr(0, 0, 32'h11);
        for (int i = 0; i < 6; i++) begin
            rd(0, 3, d);
            idle(i % 3);
        end
        idle(4);
        rd(0, 4, d); check("up_uif", d, 1);
        check("up_irq", 32'(irq), 1);
        wr(0, 4, 1);
        wr(0, 0, 0);
        wr(0, 4, 1);
        idle(1);
        check("up_irq_clr", 32'(irq), 0);

        // One-shot down count on ch2
        wr(2, 1, 0);
        wr(2, 2, 3);
        wr(2, 0, 32'h0A);
        rd(2, 3, d); check("os_load", d, 3);
        wr(2, 0, 32'h0D);
        idle(10);
        rd(2, 0, d); check("os_ctrl", d, 32'h0C);
        rd(2, 3, d); check("os_cnt", d, 3);
        rd(2, 4, d); check("os_uif", d, 1);
        wr(2, 4, 1);

        // Back-to-back writes with PSEL held, masking, error responses
        apb(1'b1, 1, 1, 32'h5, 1'b1, d, e);
        apb(1'b1, 1, 2, 32'hFFFF_FFFF, 1'b1, d, e);
        apb(1'b0, 1, 2, 32'd0, 1'b0, d, e);
        check("arr_mask", d, 32'h0000_FFFF);
        apb(1'b0, 0, 5, 32'd0, 1'b0, d, e);
        check("rsv_rdata", d, 0); check("rsv_err", 32'(e), 1);
        apb(1'b0, 5, 0, 32'd0, 1'b0, d, e);
        check("ch5_rdata", d, 0); check("ch5_err", 32'(e), 1);
        apb(1'b1, 5, 2, 32'h7, 1'b0, d, e);
        check("ch5_wr_err", 32'(e), 1);

        // PSC=0, ARR=0: update every clock, so every SR clear collides with an update
        wr(1, 1, 0);
        wr(1, 2, 0);
        wr(1, 0, 32'h11);
        wr(1, 4, 1);
        rd(1, 4, d); check("w1c_collide", d, 1);
        wr(1, 4, 1);
        check("w1c_irq", 32'(irq), 1);
        wr(1, 0, 0);
        wr(1, 4, 1);
        rd(1, 4, d); check("w1c_clear", d, 0);

        // CLR landing on a tick edge of ch3
        wr(3, 1, 1);
        wr(3, 2, 9);
        wr(3, 0, 32'h01);
        idle(5);
        waited = 0;
        while (m_pcnt[3] != 0 && waited < 10) begin cyc(); waited++; end
        check("clr_align", 32'(waited < 10), 1);
        wr(3, 0, 32'h03);
        rd(3, 3, d); check("clr_tick", d, 1);
        wr(3, 0, 0);

        // Lower ARR below CNT while counting up
        wr(0, 0, 32'h02);
        wr(0, 4, 1);
        wr(0, 1, 7);
        wr(0, 2, 10);
        wr(0, 0, 32'h01);
        waited = 0;
        while (m_cnt[0] != 7 && waited < 200) begin cyc(); waited++; end
        check("arr_wait", 32'(waited < 200), 1);
        wr(0, 2, 2);
        idle(8);
        rd(0, 4, d); check("arr_lower_uif", d, 1);
        rd(0, 3, d);
        wr(0, 0, 0);

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            int          ch, off;
            bit          w;
            logic [31:0] data;
            ch  = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, NUM_CH - 1)) : int'($urandom_range(0, 7));
            off = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
            w   = $urandom_range(0, 1);
            case (off)
                0: data = $urandom & 32'h1F;
                1: data = $urandom_range(0, 3);
                2: data = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 7);
                default: data = $urandom;
            endcase
            apb(w, ch, off, data, 1'(($urandom_range(0, 3) == 0)), d, e);
            idle($urandom_range(0, 3));
        end
        bus.PSEL = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
